// File: rtl/game_pkg.sv
// Shared types and constants for the game screen/flow sequencer.
// State encoding is visible on state_o, so the values are fixed.
package game_pkg;

    typedef enum logic [2:0] {
        MENU   = 3'd0,
        LOAD   = 3'd1,
        READY  = 3'd2,
        PLAY   = 3'd3,
        PAUSE  = 3'd4,
        RESULT = 3'd5
    } game_state_t;

    localparam logic [1:0] SCR_MENU   = 2'd0;
    localparam logic [1:0] SCR_GAME   = 2'd1;
    localparam logic [1:0] SCR_PAUSE  = 2'd2;
    localparam logic [1:0] SCR_RESULT = 2'd3;

    localparam int FRAME_CNT_W = 8;

    // Pixel-source select for each screen; unknown encodings show the menu.
    function automatic logic [1:0] screen_of(input game_state_t s);
        logic [1:0] scr;
        scr = SCR_MENU;
        case (s)
            MENU:               scr = SCR_MENU;
            LOAD, READY, PLAY:  scr = SCR_GAME;
            PAUSE:              scr = SCR_PAUSE;
            RESULT:             scr = SCR_RESULT;
            default:            scr = SCR_MENU;
        endcase
        return scr;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
// The previous-level flop resets to 1 so a button held through reset is not a press.
module btn_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic edge_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_o = sig_i & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level screen/game sequencer: menu -> load -> ready -> play <-> pause -> result -> menu.
// Owns the frame countdown, the latched map index and the pixel-source select.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int READY_FRAMES        = 120,
    parameter int RESULT_FRAMES       = 180,
    parameter int LOAD_TIMEOUT_FRAMES = 30
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic [1:0] map_type_i,
    input  logic       frame_tick_i,
    input  logic       load_done_i,
    input  logic       game_over_i,
    input  logic       victory_i,
    output logic [2:0] state_o,
    output logic [1:0] map_sel_o,
    output logic       map_load_o,
    output logic       load_err_o,
    output logic       game_run_o,
    output logic       menu_active_o,
    output logic [1:0] screen_sel_o,
    output logic       result_o
);

    localparam logic [FRAME_CNT_W-1:0] READY_LOAD   = READY_FRAMES[FRAME_CNT_W-1:0];
    localparam logic [FRAME_CNT_W-1:0] RESULT_LOAD  = RESULT_FRAMES[FRAME_CNT_W-1:0];
    localparam logic [FRAME_CNT_W-1:0] TIMEOUT_LOAD = LOAD_TIMEOUT_FRAMES[FRAME_CNT_W-1:0];
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE      = 8'd1;

    game_state_t            state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]             map_sel_q, map_sel_d;
    logic                   result_q, result_d;
    logic                   map_load_q, map_load_d;
    logic                   load_err_q, load_err_d;

    logic start_edge;
    logic pause_edge;
    logic last_tick;

    btn_edge u_start_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (start_i),
        .edge_o  (start_edge)
    );

    btn_edge u_pause_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (pause_i),
        .edge_o  (pause_edge)
    );

    // A timed state ends on the tick that finds the counter at 1, i.e. the Nth tick.
    assign last_tick = frame_tick_i && (frame_cnt_q == CNT_ONE);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        map_sel_d   = map_sel_q;
        result_d    = result_q;
        map_load_d  = 1'b0;
        load_err_d  = 1'b0;

        case (state_q)
            MENU: begin
                if (start_edge) begin
                    state_d     = LOAD;
                    map_sel_d   = map_type_i;
                    result_d    = 1'b0;
                    map_load_d  = 1'b1;
                    frame_cnt_d = TIMEOUT_LOAD;
                end
            end

            LOAD: begin
                // A load completion on the timeout tick still counts as success.
                if (load_done_i) begin
                    state_d     = READY;
                    frame_cnt_d = READY_LOAD;
                end else if (last_tick) begin
                    state_d    = MENU;
                    load_err_d = 1'b1;
                end else if (frame_tick_i) begin
                    frame_cnt_d = frame_cnt_q - CNT_ONE;
                end
            end

            READY: begin
                if (last_tick) begin
                    state_d = PLAY;
                end else if (frame_tick_i) begin
                    frame_cnt_d = frame_cnt_q - CNT_ONE;
                end
            end

            PLAY: begin
                if (game_over_i) begin
                    state_d     = RESULT;
                    result_d    = 1'b0;
                    frame_cnt_d = RESULT_LOAD;
                end else if (victory_i) begin
                    state_d     = RESULT;
                    result_d    = 1'b1;
                    frame_cnt_d = RESULT_LOAD;
                end else if (pause_edge) begin
                    state_d = PAUSE;
                end
            end

            PAUSE: begin
                if (pause_edge) begin
                    state_d = PLAY;
                end else if (start_edge) begin
                    state_d = MENU;
                end
            end

            RESULT: begin
                if (start_edge || last_tick) begin
                    state_d = MENU;
                end else if (frame_tick_i) begin
                    frame_cnt_d = frame_cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = MENU;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= MENU;
            frame_cnt_q <= '0;
            map_sel_q   <= 2'd0;
            result_q    <= 1'b0;
            map_load_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            map_sel_q   <= map_sel_d;
            result_q    <= result_d;
            map_load_q  <= map_load_d;
            load_err_q  <= load_err_d;
        end
    end

    assign state_o       = state_q;
    assign map_sel_o     = map_sel_q;
    assign map_load_o    = map_load_q;
    assign load_err_o    = load_err_q;
    assign result_o      = result_q;
    assign menu_active_o = (state_q == MENU);
    assign game_run_o    = (state_q == PLAY);
    assign screen_sel_o  = screen_of(state_q);

endmodule
